// File: rtl/c4_pkg.sv
// Shared Connect 4 definitions: board geometry, cell/winner codes, FSM states
// and the column/row to RAM address mapping.
package c4_pkg;
  localparam int NUM_COLS    = 7;
  localparam int NUM_ROWS    = 6;
  localparam int BOARD_CELLS = NUM_COLS * NUM_ROWS;

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] P1    = 2'd1;
  localparam logic [1:0] P2    = 2'd2;

  localparam logic [1:0] WIN_NONE = 2'd0;
  localparam logic [1:0] WIN_P1   = 2'd1;
  localparam logic [1:0] WIN_P2   = 2'd2;
  localparam logic [1:0] TIE      = 2'd3;

  typedef enum logic [2:0] {CLEAR, IDLE, SCAN, WRITE, CHECK, DONE} state_t;

  // col*6 as (col<<2)+(col<<1), kept 6 bits wide (max 41)
  function automatic logic [5:0] cell_addr(input logic [2:0] col, input logic [2:0] row);
    return {1'b0, col, 2'b00} + {2'b00, col, 1'b0} + {3'b000, row};
  endfunction
endpackage

// File: rtl/c4_cursor.sv
// Wrapping cursor column counter; left+right together cancel, load restores the start column.
module c4_cursor #(
  parameter int NUM_COLS  = 7,
  parameter int START_COL = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       left,
  input  logic       right,
  input  logic       load,
  output logic [2:0] col
);
  import c4_pkg::*;

  localparam logic [2:0] LAST  = 3'(NUM_COLS - 1);
  localparam logic [2:0] START = 3'(START_COL);

  always_ff @(posedge clk) begin
    if (reset || load)
      col <= START;
    else if (left && !right)
      col <= (col == 3'd0) ? LAST : col - 3'd1;
    else if (right && !left)
      col <= (col == LAST) ? 3'd0 : col + 3'd1;
  end
endmodule

// File: rtl/c4_move_controller.sv
// Connect 4 game-control FSM: clears the board RAM, scans the cursor column for
// the lowest empty cell, writes the current player's piece and evaluates the result.
module c4_move_controller #(
  parameter int NUM_COLS  = 7,
  parameter int NUM_ROWS  = 6,
  parameter int START_COL = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_drop,
  input  logic [1:0] sm_output,
  input  logic       p1_four_row,
  input  logic       p2_four_row,
  input  logic       tie_game,
  output logic       write_EN,
  output logic [1:0] input_data,
  output logic [5:0] write_addr_sm,
  output logic [5:0] read_addr_sm,
  output logic [2:0] cursor_col,
  output logic [1:0] cur_player,
  output logic       busy,
  output logic       illegal_move,
  output logic       game_over,
  output logic [1:0] winner
);
  import c4_pkg::*;

  localparam logic [5:0] LAST_CELL = 6'(NUM_COLS * NUM_ROWS - 1);
  localparam logic [2:0] TOP_ROW   = 3'(NUM_ROWS - 1);

  state_t     state;
  logic [5:0] clr_addr;
  logic [2:0] scan_row;
  logic [5:0] scan_addr;
  logic       cur_left, cur_right, cur_load;

  assign scan_addr    = cell_addr(cursor_col, scan_row);
  assign read_addr_sm = scan_addr;

  // Cursor only moves in IDLE, and a drop in the same cycle wins over movement
  assign cur_left  = (state == IDLE) && btn_left  && !btn_drop;
  assign cur_right = (state == IDLE) && btn_right && !btn_drop;
  assign cur_load  = (state == DONE) && btn_drop;

  c4_cursor #(
    .NUM_COLS  (NUM_COLS),
    .START_COL (START_COL)
  ) u_cursor (
    .clk   (clk),
    .reset (reset),
    .left  (cur_left),
    .right (cur_right),
    .load  (cur_load),
    .col   (cursor_col)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= CLEAR;
      clr_addr      <= 6'd0;
      scan_row      <= 3'd0;
      write_EN      <= 1'b1;
      write_addr_sm <= 6'd0;
      input_data    <= EMPTY;
      cur_player    <= P1;
      busy          <= 1'b1;
      illegal_move  <= 1'b0;
      game_over     <= 1'b0;
      winner        <= WIN_NONE;
    end else begin
      illegal_move <= 1'b0;
      case (state)
        CLEAR: begin
          if (clr_addr == LAST_CELL) begin
            write_EN <= 1'b0;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            clr_addr      <= clr_addr + 6'd1;
            write_addr_sm <= clr_addr + 6'd1;
          end
        end
        IDLE: begin
          if (btn_drop) begin
            scan_row <= 3'd0;
            busy     <= 1'b1;
            state    <= SCAN;
          end
        end
        SCAN: begin
          if (sm_output == EMPTY) begin
            write_addr_sm <= scan_addr;
            input_data    <= cur_player;
            write_EN      <= 1'b1;
            state         <= WRITE;
          end else if (scan_row == TOP_ROW) begin
            illegal_move <= 1'b1;
            busy         <= 1'b0;
            state        <= IDLE;
          end else begin
            scan_row <= scan_row + 3'd1;
          end
        end
        WRITE: begin
          write_EN <= 1'b0;
          state    <= CHECK;
        end
        CHECK: begin
          // RAM took the write on the WRITE edge, so the flags already include the new piece
          busy <= 1'b0;
          if (p1_four_row) begin
            winner    <= WIN_P1;
            game_over <= 1'b1;
            state     <= DONE;
          end else if (p2_four_row) begin
            winner    <= WIN_P2;
            game_over <= 1'b1;
            state     <= DONE;
          end else if (tie_game) begin
            winner    <= TIE;
            game_over <= 1'b1;
            state     <= DONE;
          end else begin
            cur_player <= (cur_player == P1) ? P2 : P1;
            state      <= IDLE;
          end
        end
        DONE: begin
          if (btn_drop) begin
            winner        <= WIN_NONE;
            game_over     <= 1'b0;
            cur_player    <= P1;
            clr_addr      <= 6'd0;
            write_addr_sm <= 6'd0;
            input_data    <= EMPTY;
            write_EN      <= 1'b1;
            busy          <= 1'b1;
            state         <= CLEAR;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end
endmodule
